// File: rtl/huffman_tree_builder_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : huffman_tree_builder_if                                     |
// | Description : Request/weight and node-record bundle for the 4-leaf        |
// |               Huffman tree builder.                                       |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
interface huffman_tree_builder_if #(
   parameter int WEIGHT_W = 8
);
   logic                start;
   logic [WEIGHT_W-1:0] weight_1;
   logic [WEIGHT_W-1:0] weight_2;
   logic [WEIGHT_W-1:0] weight_3;
   logic [WEIGHT_W-1:0] weight_4;
   logic [12:0]         info_node_1;
   logic [12:0]         info_node_2;
   logic [12:0]         info_node_3;
   logic [12:0]         info_node_4;
   logic [12:0]         info_node_5;
   logic [12:0]         info_node_6;
   logic [12:0]         info_node_7;
   logic [WEIGHT_W+1:0] root_weight;
   logic                busy;
   logic                done;
   logic                tree_valid;

   // Requester side: issues start and weights, observes the tree.
   modport master (
      output start, weight_1, weight_2, weight_3, weight_4,
      input  info_node_1, info_node_2, info_node_3, info_node_4,
             info_node_5, info_node_6, info_node_7,
             root_weight, busy, done, tree_valid
   );

   // Builder side.
   modport slave (
      input  start, weight_1, weight_2, weight_3, weight_4,
      output info_node_1, info_node_2, info_node_3, info_node_4,
             info_node_5, info_node_6, info_node_7,
             root_weight, busy, done, tree_valid
   );
endinterface
`default_nettype wire

// File: rtl/huffman_tree_builder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : huffman_tree_builder                                        |
// | Description : Builds a 4-leaf Huffman tree (7 nodes, root = node 7) by    |
// |               repeated min-pair scans and merges, then derives depths and |
// |               emits 13-bit node records {depth,branch,parent,id}.         |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module huffman_tree_builder #(
   parameter int WEIGHT_W = 8
) (
   input  logic                  CLK,
   input  logic                  nRST,
   huffman_tree_builder_if.slave bus
);
   localparam int SUM_W = WEIGHT_W + 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SCAN  = 3'd1,
      S_MERGE = 3'd2,
      S_DEPTH = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   // Per-node working storage, indexed by node id 1..7.
   logic [SUM_W-1:0] r_w      [1:7];
   logic [2:0]       r_parent [1:7];
   logic [1:0]       r_depth  [1:7];
   logic [7:1]       r_branch;
   logic [7:1]       r_active;

   logic [2:0]       r_idx;
   logic [2:0]       r_next_id;
   logic [2:0]       r_m1_idx;
   logic [2:0]       r_m2_idx;
   logic [SUM_W-1:0] r_m1_w;
   logic [SUM_W-1:0] r_m2_w;
   logic             r_m1_vld;
   logic             r_m2_vld;

   logic [12:0]      r_info [1:7];
   logic [SUM_W-1:0] r_root;
   logic             r_busy;
   logic             r_done;
   logic             r_tree_valid;

   logic [SUM_W-1:0] w_cur_w;

   assign w_cur_w = r_w[r_idx];

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state selection: 7 scan cycles + 1 merge per internal node, 7 depth cycles, 1 finish.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_SCAN;
         S_SCAN:  if (r_idx == 3'd7) w_state_nxt = S_MERGE;
         S_MERGE: w_state_nxt = (r_next_id == 3'd7) ? S_DEPTH : S_SCAN;
         S_DEPTH: if (r_idx == 3'd1) w_state_nxt = S_FIN;
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: weight latch, min-pair search, merge, depth walk and record publication.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 1; i <= 7; i++) begin
            r_w[i]      <= '0;
            r_parent[i] <= '0;
            r_depth[i]  <= '0;
            r_info[i]   <= '0;
         end
         r_branch     <= '0;
         r_active     <= '0;
         r_idx        <= '0;
         r_next_id    <= '0;
         r_m1_idx     <= '0;
         r_m2_idx     <= '0;
         r_m1_w       <= '0;
         r_m2_w       <= '0;
         r_m1_vld     <= 1'b0;
         r_m2_vld     <= 1'b0;
         r_root       <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_tree_valid <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_w[1]       <= {2'b00, bus.weight_1};
                  r_w[2]       <= {2'b00, bus.weight_2};
                  r_w[3]       <= {2'b00, bus.weight_3};
                  r_w[4]       <= {2'b00, bus.weight_4};
                  r_w[5]       <= '0;
                  r_w[6]       <= '0;
                  r_w[7]       <= '0;
                  r_active     <= 7'b0001111;
                  r_next_id    <= 3'd5;
                  r_idx        <= 3'd1;
                  r_m1_vld     <= 1'b0;
                  r_m2_vld     <= 1'b0;
                  r_busy       <= 1'b1;
                  r_tree_valid <= 1'b0;
               end
            end
            S_SCAN: begin
               // Strict less-than while scanning upward keeps the lower index on ties.
               if (r_active[r_idx]) begin
                  if (!r_m1_vld || (w_cur_w < r_m1_w)) begin
                     r_m2_idx <= r_m1_idx;
                     r_m2_w   <= r_m1_w;
                     r_m2_vld <= r_m1_vld;
                     r_m1_idx <= r_idx;
                     r_m1_w   <= w_cur_w;
                     r_m1_vld <= 1'b1;
                  end else if (!r_m2_vld || (w_cur_w < r_m2_w)) begin
                     r_m2_idx <= r_idx;
                     r_m2_w   <= w_cur_w;
                     r_m2_vld <= 1'b1;
                  end
               end
               r_idx <= r_idx + 3'd1;
            end
            S_MERGE: begin
               r_w[r_next_id]      <= r_w[r_m1_idx] + r_w[r_m2_idx];
               r_parent[r_m1_idx]  <= r_next_id;
               r_branch[r_m1_idx]  <= 1'b0;
               r_parent[r_m2_idx]  <= r_next_id;
               r_branch[r_m2_idx]  <= 1'b1;
               r_active[r_m1_idx]  <= 1'b0;
               r_active[r_m2_idx]  <= 1'b0;
               r_active[r_next_id] <= 1'b1;
               r_m1_vld            <= 1'b0;
               r_m2_vld            <= 1'b0;
               if (r_next_id == 3'd7) begin
                  r_idx <= 3'd7;
               end else begin
                  r_idx     <= 3'd1;
                  r_next_id <= r_next_id + 3'd1;
               end
            end
            S_DEPTH: begin
               // Parents always carry a higher id, so a descending walk sees their depth first.
               if (r_idx == 3'd7) begin
                  r_depth[7]  <= 2'd0;
                  r_parent[7] <= 3'd7;
                  r_branch[7] <= 1'b0;
               end else begin
                  r_depth[r_idx] <= r_depth[r_parent[r_idx]] + 2'd1;
               end
               r_idx <= r_idx - 3'd1;
            end
            S_FIN: begin
               for (int i = 1; i <= 7; i++) begin
                  r_info[i] <= {2'b00, r_depth[i], r_branch[i], 1'b0, r_parent[i], 4'(i)};
               end
               r_root       <= r_w[7];
               r_done       <= 1'b1;
               r_busy       <= 1'b0;
               r_tree_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.info_node_1 = r_info[1];
   assign bus.info_node_2 = r_info[2];
   assign bus.info_node_3 = r_info[3];
   assign bus.info_node_4 = r_info[4];
   assign bus.info_node_5 = r_info[5];
   assign bus.info_node_6 = r_info[6];
   assign bus.info_node_7 = r_info[7];
   assign bus.root_weight = r_root;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.tree_valid  = r_tree_valid;
endmodule
`default_nettype wire

// File: tb/tb_huffman_tree_builder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_huffman_tree_builder                                     |
// | Description : Directed self-checking bench for huffman_tree_builder with  |
// |               hand-computed node records.                                 |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_huffman_tree_builder;
   logic CLK;
   logic nRST;
   int   r_errors;
   int   r_checks;
   int   lat;
   bit   saw_done;

   huffman_tree_builder_if #(.WEIGHT_W(8)) bus ();

   huffman_tree_builder #(.WEIGHT_W(8)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      r_checks++;
      if (got !== exp) begin
         r_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_recs(input string tag,
                             input logic [12:0] e1, input logic [12:0] e2, input logic [12:0] e3,
                             input logic [12:0] e4, input logic [12:0] e5, input logic [12:0] e6,
                             input logic [12:0] e7, input logic [9:0] er);
      check({tag, "_n1"},   32'(bus.info_node_1), 32'(e1));
      check({tag, "_n2"},   32'(bus.info_node_2), 32'(e2));
      check({tag, "_n3"},   32'(bus.info_node_3), 32'(e3));
      check({tag, "_n4"},   32'(bus.info_node_4), 32'(e4));
      check({tag, "_n5"},   32'(bus.info_node_5), 32'(e5));
      check({tag, "_n6"},   32'(bus.info_node_6), 32'(e6));
      check({tag, "_n7"},   32'(bus.info_node_7), 32'(e7));
      check({tag, "_root"}, 32'(bus.root_weight), 32'(er));
   endtask

   // Issues one start; lat counts edges with the start-sampling edge as 1.
   // Optional start re-pulse and reset are injected at the given latency (0 = none).
   task automatic run_tree(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input int repulse_at, input int reset_at,
                           output int n, output bit seen);
      @(negedge CLK);
      bus.weight_1 = a;
      bus.weight_2 = b;
      bus.weight_3 = c;
      bus.weight_4 = d;
      bus.start    = 1'b1;
      @(posedge CLK);
      n    = 1;
      seen = 1'b0;
      @(negedge CLK);
      bus.start = 1'b0;
      check("busy_after_start", 32'(bus.busy), 32'd1);
      check("valid_low_in_build", 32'(bus.tree_valid), 32'd0);
      while (n < 80) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (n == repulse_at) begin
            bus.weight_1 = 8'd1;
            bus.weight_2 = 8'd1;
            bus.weight_3 = 8'd1;
            bus.weight_4 = 8'd1;
            bus.start    = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         if (n == reset_at) begin
            nRST = 1'b0;
            #1;
            check("rst_n1_zero",   32'(bus.info_node_1), 32'd0);
            check("rst_n7_zero",   32'(bus.info_node_7), 32'd0);
            check("rst_root_zero", 32'(bus.root_weight), 32'd0);
            check("rst_busy_zero", 32'(bus.busy),        32'd0);
         end
         @(posedge CLK);
         n++;
         @(negedge CLK);
         nRST = 1'b1;
      end
      bus.start = 1'b0;
   endtask

   initial begin
      r_errors     = 0;
      r_checks     = 0;
      nRST         = 1'b0;
      bus.start    = 1'b0;
      bus.weight_1 = '0;
      bus.weight_2 = '0;
      bus.weight_3 = '0;
      bus.weight_4 = '0;

      // Reset state, observed after a clock edge inside reset.
      #7;
      check("reset_n1",    32'(bus.info_node_1), 32'd0);
      check("reset_n7",    32'(bus.info_node_7), 32'd0);
      check("reset_root",  32'(bus.root_weight), 32'd0);
      check("reset_busy",  32'(bus.busy),        32'd0);
      check("reset_done",  32'(bus.done),        32'd0);
      check("reset_valid", 32'(bus.tree_valid),  32'd0);
      @(negedge CLK);
      nRST = 1'b1;

      // 10,20,30,40: (1,2)->5 w30, (3,5)->6 w60, (4,6)->7 w100.
      run_tree(8'd10, 8'd20, 8'd30, 8'd40, 0, 0, lat, saw_done);
      check("asc_done_seen", 32'(saw_done), 32'd1);
      check("asc_latency",   32'(lat),      32'd33);
      check("asc_busy_low",  32'(bus.busy), 32'd0);
      check("asc_valid",     32'(bus.tree_valid), 32'd1);
      check_recs("asc", 13'h0651, 13'h0752, 13'h0463, 13'h0274, 13'h0565, 13'h0376, 13'h0077, 10'd100);
      @(negedge CLK);
      check("asc_done_pulse", 32'(bus.done),       32'd0);
      check("asc_valid_hold", 32'(bus.tree_valid), 32'd1);

      // Equal weights: (1,2)->5, (3,4)->6, (5,6)->7.
      run_tree(8'd5, 8'd5, 8'd5, 8'd5, 0, 0, lat, saw_done);
      check("eq_latency", 32'(lat), 32'd33);
      check_recs("eq", 13'h0451, 13'h0552, 13'h0463, 13'h0564, 13'h0275, 13'h0376, 13'h0077, 10'd20);

      // Maximum weights: same shape, 10-bit root with no wrap.
      run_tree(8'd255, 8'd255, 8'd255, 8'd255, 0, 0, lat, saw_done);
      check("max_latency", 32'(lat), 32'd33);
      check_recs("max", 13'h0451, 13'h0552, 13'h0463, 13'h0564, 13'h0275, 13'h0376, 13'h0077, 10'd1020);

      // Zeros: (1,2)->5 w0, (4,5)->6 w0, then node 6 (w0) is the lighter
      // child of the root and takes branch 0, node 3 (w7) takes branch 1.
      run_tree(8'd0, 8'd0, 8'd7, 8'd0, 0, 0, lat, saw_done);
      check("zero_latency", 32'(lat), 32'd33);
      check_recs("zero", 13'h0651, 13'h0752, 13'h0373, 13'h0464, 13'h0565, 13'h0276, 13'h0077, 10'd7);

      // Re-pulse at +5 with other weights: ignored, timing and result unchanged.
      fork
         begin
            repeat (3) @(negedge CLK);
            check("rebuild_hold_n3", 32'(bus.info_node_3), 32'h0373);
         end
      join_none
      run_tree(8'd10, 8'd20, 8'd30, 8'd40, 5, 0, lat, saw_done);
      check("repulse_latency", 32'(lat), 32'd33);
      check_recs("repulse", 13'h0651, 13'h0752, 13'h0463, 13'h0274, 13'h0565, 13'h0376, 13'h0077, 10'd100);
      @(negedge CLK);
      check("repulse_idle_busy", 32'(bus.busy), 32'd0);

      // Reset at +12 aborts the build with no done pulse.
      run_tree(8'd5, 8'd5, 8'd5, 8'd5, 0, 12, lat, saw_done);
      check("abort_no_done", 32'(saw_done), 32'd0);
      check("abort_valid",   32'(bus.tree_valid), 32'd0);

      // Fresh build after the abort.
      run_tree(8'd10, 8'd20, 8'd30, 8'd40, 0, 0, lat, saw_done);
      check("post_rst_latency", 32'(lat), 32'd33);
      check_recs("post_rst", 13'h0651, 13'h0752, 13'h0463, 13'h0274, 13'h0565, 13'h0376, 13'h0077, 10'd100);

      $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
      $finish;
   end
endmodule
`default_nettype wire
